y_sram_ctrl: RTL and testbench
==============================

Name: y_sram_ctrl

Overview:
- Controller for the Y SRAM: one write port, two read ports, 2^AW rows of DW bits.
- Shares the single write port between two write requesters (A, B) using round-robin arbitration.
- Runs a burst read sequencer that drives both read ports with consecutive row pairs and returns data with a valid strobe.
- Sits between the compute datapath and the Y SRAM instance inside the memory wrapper.

Parameters:
AW, 11, row address width (Y SRAM depth = 2^AW)
DW, 256, row data width
RD_LAT, 1, Y SRAM read latency in clocks, from address to ReadBus (must be >= 1)

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
wr_req_a  input  1  requester A write request
wr_addr_a  input  AW  requester A write address
wr_data_a  input  DW  requester A write data
wr_gnt_a  output  1  combinational grant to A; request is consumed this cycle
wr_req_b / wr_addr_b / wr_data_b / wr_gnt_b  as for A
rd_start  input  1  start burst read (accepted only when rd_busy=0)
rd_base  input  AW  first row of burst
rd_pairs  input  AW  number of row pairs to read (0 = empty burst)
rd_busy  output  1  sequencer not idle
rd_valid  output  1  rd_data0/rd_data1 valid this cycle
rd_data0  output  DW  row p (pass-through of Y_ReadBus1)
rd_data1  output  DW  row p+1 (pass-through of Y_ReadBus2)
rd_done  output  1  one-cycle pulse at end of burst
Y_WE  output  1  SRAM write enable (registered)
Y_WriteAddress  output  AW  registered
Y_WriteBus  output  DW  registered
Y_ReadAddress1  output  AW  registered; row p
Y_ReadAddress2  output  AW  registered; row p+1
Y_ReadBus1  input  DW  SRAM read data, port 1
Y_ReadBus2  input  DW  SRAM read data, port 2

Behaviour:
- Reset (async) values:
  - Outputs: Y_WE=0, Y_WriteAddress=0, Y_WriteBus=0, Y_ReadAddress1=0, Y_ReadAddress2=1, rd_busy=0, rd_valid=0, rd_done=0.
  - State: read FSM=IDLE, valid pipeline cleared, round-robin priority = A.
- Write arbiter:
  - Single requester: that requester is granted.
  - Both requesting: grant goes to the requester that did not win the last grant; priority flips only when a grant is issued.
  - At most one grant per cycle.
  - Next edge: Y_WE<=1 and address/data of the granted requester are registered; otherwise Y_WE<=0.
  - Write latency: grant cycle + 1.
- Read FSM states:
  - IDLE: on rd_start, load ptr=rd_base and remaining=rd_pairs.
    - rd_pairs=0: rd_done pulses next cycle and FSM stays IDLE.
    - Otherwise: go to ISSUE; rd_busy=1 from the next cycle.
  - ISSUE: each cycle, issue pair (ptr, ptr+1 mod 2^AW) on Y_ReadAddress1/2, then ptr += 2 (mod 2^AW wrap) and remaining -= 1.
    - After the issue with remaining=1, go to DRAIN.
  - Hazard stall: if Y_WE=1 this cycle and Y_WriteAddress equals ptr or ptr+1, skip the issue this cycle (no address change, no valid injected) and retry next cycle.
  - DRAIN: wait RD_LAT cycles for the last data to return, then go to IDLE.
    - rd_done pulses together with the final rd_valid.
    - rd_busy=0 in the following cycle.
- Data return:
  - rd_valid is asserted exactly RD_LAT cycles after each issue (valid shift register, depth RD_LAT).
  - rd_data0/1 are combinational pass-throughs of Y_ReadBus1/2.
- rd_start is ignored while rd_busy=1 or during the rd_done cycle.
- Writes and reads proceed concurrently; the read sequencer never blocks grants.
- Reset mid-burst: FSM returns to IDLE, pending valids are discarded, no rd_done is issued.

Test Plan:
- Reset with wr_req_a=1 held -> Y_WE=0 and wr_gnt_a is ignored during reset; first edge after release -> Y_WE=1 with A's address/data.
- wr_req_a and wr_req_b both held for 4 cycles -> grants A,B,A,B; Y_WriteAddress alternates between wr_addr_a and wr_addr_b, one cycle behind each grant.
- Preload rows 10..15 with 10+i; rd_start with base=10, pairs=3 -> rd_valid for 3 consecutive cycles carrying (10,11),(12,13),(14,15); rd_done coincident with the third rd_valid.
- Wrap: base=2046, pairs=2 -> issued addresses (2046,2047) then (0,1).
- Hazard: write to row 13 with Y_WE=1 in the cycle the pair (12,13) would issue -> that issue stalls one cycle; the returned row 13 holds the new data.
- rd_pairs=0 -> rd_done pulses after one cycle and rd_valid is never asserted; reset asserted mid-burst -> rd_valid and rd_busy drop immediately, no rd_done.

Source files
------------

// File: rtl/y_sram_ctrl.sv
// Y SRAM controller: round-robin arbitration of two write requesters onto the
// single write port, and a burst sequencer that reads consecutive row pairs.
module y_sram_ctrl #(
    parameter int AW     = 11,
    parameter int DW     = 256,
    parameter int RD_LAT = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_req_a,
    input  logic [AW-1:0] wr_addr_a,
    input  logic [DW-1:0] wr_data_a,
    output logic          wr_gnt_a,
    input  logic          wr_req_b,
    input  logic [AW-1:0] wr_addr_b,
    input  logic [DW-1:0] wr_data_b,
    output logic          wr_gnt_b,
    input  logic          rd_start,
    input  logic [AW-1:0] rd_base,
    input  logic [AW-1:0] rd_pairs,
    output logic          rd_busy,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data0,
    output logic [DW-1:0] rd_data1,
    output logic          rd_done,
    output logic          Y_WE,
    output logic [AW-1:0] Y_WriteAddress,
    output logic [DW-1:0] Y_WriteBus,
    output logic [AW-1:0] Y_ReadAddress1,
    output logic [AW-1:0] Y_ReadAddress2,
    input  logic [DW-1:0] Y_ReadBus1,
    input  logic [DW-1:0] Y_ReadBus2
);

    localparam int            CW  = $clog2(RD_LAT + 2);
    localparam logic [AW-1:0] ONE = AW'(1);
    localparam logic [AW-1:0] TWO = AW'(2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Write arbiter state; r_prio=1 means B wins the next tie.
    logic          r_prio;
    logic          r_we;
    logic [AW-1:0] r_waddr;
    logic [DW-1:0] r_wdata;
    logic          w_gnt_a;
    logic          w_gnt_b;

    // Read sequencer state
    state_t        r_state;
    logic [AW-1:0] r_ptr;
    logic [AW-1:0] r_rem;
    logic [AW-1:0] r_raddr1;
    logic [AW-1:0] r_raddr2;
    logic [CW-1:0] r_cnt;
    logic [RD_LAT:0] r_vpipe;
    logic          r_busy;
    logic          r_done;
    logic [AW-1:0] w_ptr_p1;
    logic          w_hazard;
    logic          w_issue;
    logic          w_start;

    // Round-robin grant decision; nothing is granted while reset is held.
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (reset) begin
            w_gnt_a = 1'b0;
            w_gnt_b = 1'b0;
        end else if (wr_req_a && wr_req_b) begin
            w_gnt_a = ~r_prio;
            w_gnt_b = r_prio;
        end else begin
            w_gnt_a = wr_req_a;
            w_gnt_b = wr_req_b;
        end
    end

    // Register the granted write onto the SRAM write port and flip priority.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_prio  <= 1'b0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_gnt_a | w_gnt_b;
            if (w_gnt_a) begin
                r_waddr <= wr_addr_a;
                r_wdata <= wr_data_a;
                r_prio  <= 1'b1;
            end else if (w_gnt_b) begin
                r_waddr <= wr_addr_b;
                r_wdata <= wr_data_b;
                r_prio  <= 1'b0;
            end
        end
    end

    // Issue decision: a pending write to either row of the pair defers the issue.
    always_comb begin
        w_ptr_p1 = r_ptr + ONE;
        w_hazard = r_we && ((r_waddr == r_ptr) || (r_waddr == w_ptr_p1));
        w_issue  = (r_state == S_ISSUE) && !w_hazard;
        w_start  = rd_start && !r_busy && !r_done && (r_state == S_IDLE);
    end

    // Burst read FSM: IDLE -> ISSUE (one pair per cycle) -> DRAIN -> IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_rem    <= '0;
            r_raddr1 <= '0;
            r_raddr2 <= ONE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    if (w_start) begin
                        r_ptr <= rd_base;
                        r_rem <= rd_pairs;
                        if (rd_pairs == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_ISSUE;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_issue) begin
                        r_raddr1 <= r_ptr;
                        r_raddr2 <= w_ptr_p1;
                        r_ptr    <= r_ptr + TWO;
                        r_rem    <= r_rem - ONE;
                        if (r_rem == ONE) begin
                            r_state <= S_DRAIN;
                            r_cnt   <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    // rd_done lines up with the last valid; busy drops a cycle later.
                    if (r_cnt == CW'(RD_LAT)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CW'(RD_LAT - 1)) begin
                            r_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Valid pipeline: bit 0 is aligned with the issued addresses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vpipe <= '0;
        end else begin
            r_vpipe <= {r_vpipe[RD_LAT-1:0], w_issue};
        end
    end

    assign wr_gnt_a       = w_gnt_a;
    assign wr_gnt_b       = w_gnt_b;
    assign Y_WE           = r_we;
    assign Y_WriteAddress = r_waddr;
    assign Y_WriteBus     = r_wdata;
    assign Y_ReadAddress1 = r_raddr1;
    assign Y_ReadAddress2 = r_raddr2;
    assign rd_busy        = r_busy;
    assign rd_done        = r_done;
    assign rd_valid       = r_vpipe[RD_LAT];
    assign rd_data0       = Y_ReadBus1;
    assign rd_data1       = Y_ReadBus2;

endmodule

// File: tb/tb_y_sram_ctrl.sv
// Directed bench for y_sram_ctrl with a behavioural 1-cycle-latency Y SRAM.
module tb_y_sram_ctrl;

    localparam int AW = 11;
    localparam int DW = 256;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          wr_req_a = 1'b0, wr_req_b = 1'b0;
    logic [AW-1:0] wr_addr_a = '0, wr_addr_b = '0;
    logic [DW-1:0] wr_data_a = '0, wr_data_b = '0;
    logic          wr_gnt_a, wr_gnt_b;
    logic          rd_start = 1'b0;
    logic [AW-1:0] rd_base = '0, rd_pairs = '0;
    logic          rd_busy, rd_valid, rd_done;
    logic [DW-1:0] rd_data0, rd_data1;
    logic          Y_WE;
    logic [AW-1:0] Y_WriteAddress, Y_ReadAddress1, Y_ReadAddress2;
    logic [DW-1:0] Y_WriteBus;
    logic [DW-1:0] Y_ReadBus1 = '0, Y_ReadBus2 = '0;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    int n_cmp = 0;
    int n_err = 0;

    y_sram_ctrl #(.AW(AW), .DW(DW), .RD_LAT(1)) dut (
        .clock(clock), .reset(reset),
        .wr_req_a(wr_req_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a), .wr_gnt_a(wr_gnt_a),
        .wr_req_b(wr_req_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b), .wr_gnt_b(wr_gnt_b),
        .rd_start(rd_start), .rd_base(rd_base), .rd_pairs(rd_pairs),
        .rd_busy(rd_busy), .rd_valid(rd_valid), .rd_data0(rd_data0), .rd_data1(rd_data1),
        .rd_done(rd_done),
        .Y_WE(Y_WE), .Y_WriteAddress(Y_WriteAddress), .Y_WriteBus(Y_WriteBus),
        .Y_ReadAddress1(Y_ReadAddress1), .Y_ReadAddress2(Y_ReadAddress2),
        .Y_ReadBus1(Y_ReadBus1), .Y_ReadBus2(Y_ReadBus2)
    );

    always #5 clock = ~clock;

    // SRAM model: write-then-read ordering gives old data on same-edge collisions.
    always @(posedge clock) begin
        if (Y_WE) mem[Y_WriteAddress] <= Y_WriteBus;
        Y_ReadBus1 <= mem[Y_ReadAddress1];
        Y_ReadBus2 <= mem[Y_ReadAddress2];
    end

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_burst(input int base, input int pairs);
        rd_start = 1'b1;
        rd_base  = AW'(base);
        rd_pairs = AW'(pairs);
        @(negedge clock);
        rd_start = 1'b0;
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

        // Reset held with A requesting
        wr_req_a  = 1'b1;
        wr_addr_a = AW'(5);
        wr_data_a = DW'(32'hAA);
        @(negedge clock);
        @(negedge clock);
        check_eq("rst_we", DW'(Y_WE), DW'(0));
        check_eq("rst_gnt_a", DW'(wr_gnt_a), DW'(0));
        check_eq("rst_waddr", DW'(Y_WriteAddress), DW'(0));
        check_eq("rst_raddr1", DW'(Y_ReadAddress1), DW'(0));
        check_eq("rst_raddr2", DW'(Y_ReadAddress2), DW'(1));
        check_eq("rst_busy", DW'(rd_busy), DW'(0));
        check_eq("rst_valid", DW'(rd_valid), DW'(0));
        check_eq("rst_done", DW'(rd_done), DW'(0));
        reset = 1'b0;
        #1;
        check_eq("post_rst_gnt_a", DW'(wr_gnt_a), DW'(1));
        @(negedge clock);
        check_eq("post_rst_we", DW'(Y_WE), DW'(1));
        check_eq("post_rst_waddr", DW'(Y_WriteAddress), DW'(5));
        check_eq("post_rst_wdata", Y_WriteBus, DW'(32'hAA));
        wr_req_a = 1'b0;

        // Fresh priority, then both requesting for 4 cycles: A,B,A,B
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        wr_req_a = 1'b1; wr_addr_a = AW'(20); wr_data_a = DW'(32'h2020);
        wr_req_b = 1'b1; wr_addr_b = AW'(30); wr_data_b = DW'(32'h3030);
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("rr_gnt_a", DW'(wr_gnt_a), DW'((i % 2) == 0));
            check_eq("rr_gnt_b", DW'(wr_gnt_b), DW'((i % 2) == 1));
            @(negedge clock);
            check_eq("rr_we", DW'(Y_WE), DW'(1));
            check_eq("rr_waddr", DW'(Y_WriteAddress), DW'(((i % 2) == 0) ? 20 : 30));
        end
        wr_req_a = 1'b0;
        wr_req_b = 1'b0;
        @(negedge clock);

        // Preload rows 10..15 with their own row number
        for (int i = 0; i < 6; i++) begin
            wr_req_a = 1'b1; wr_addr_a = AW'(10 + i); wr_data_a = DW'(10 + i);
            @(negedge clock);
        end
        wr_req_a = 1'b0;
        @(negedge clock);
        @(negedge clock);

        // Burst base=10 pairs=3
        start_burst(10, 3);
        check_eq("b1_busy", DW'(rd_busy), DW'(1));
        cnt = 1;
        while (!rd_valid && cnt < 10) begin
            @(negedge clock);
            cnt++;
        end
        check_eq("b1_latency", DW'(cnt), DW'(3));
        for (int k = 0; k < 3; k++) begin
            check_eq("b1_valid", DW'(rd_valid), DW'(1));
            check_eq("b1_data0", rd_data0, DW'(10 + 2 * k));
            check_eq("b1_data1", rd_data1, DW'(11 + 2 * k));
            check_eq("b1_done", DW'(rd_done), DW'(k == 2));
            @(negedge clock);
        end
        check_eq("b1_busy_end", DW'(rd_busy), DW'(0));
        check_eq("b1_valid_end", DW'(rd_valid), DW'(0));
        check_eq("b1_done_end", DW'(rd_done), DW'(0));

        // Address wrap: base=2046 pairs=2
        start_burst(2046, 2);
        @(negedge clock);
        check_eq("wrap_a1_0", DW'(Y_ReadAddress1), DW'(2046));
        check_eq("wrap_a2_0", DW'(Y_ReadAddress2), DW'(2047));
        @(negedge clock);
        check_eq("wrap_a1_1", DW'(Y_ReadAddress1), DW'(0));
        check_eq("wrap_a2_1", DW'(Y_ReadAddress2), DW'(1));
        @(negedge clock);
        check_eq("wrap_done", DW'(rd_done), DW'(1));
        check_eq("wrap_valid", DW'(rd_valid), DW'(1));
        @(negedge clock);
        check_eq("wrap_busy_end", DW'(rd_busy), DW'(0));

        // Hazard: row 13 written while pair (12,13) is due
        start_burst(10, 3);
        wr_req_a = 1'b1; wr_addr_a = AW'(13); wr_data_a = DW'(32'h99);
        @(negedge clock);
        wr_req_a = 1'b0;
        check_eq("hz_we", DW'(Y_WE), DW'(1));
        check_eq("hz_a1_first", DW'(Y_ReadAddress1), DW'(10));
        @(negedge clock);
        check_eq("hz_valid0", DW'(rd_valid), DW'(1));
        check_eq("hz_data0_0", rd_data0, DW'(10));
        check_eq("hz_stall_addr", DW'(Y_ReadAddress1), DW'(10));
        @(negedge clock);
        check_eq("hz_stall_valid", DW'(rd_valid), DW'(0));
        check_eq("hz_a1_retry", DW'(Y_ReadAddress1), DW'(12));
        @(negedge clock);
        check_eq("hz_valid1", DW'(rd_valid), DW'(1));
        check_eq("hz_data0_1", rd_data0, DW'(12));
        check_eq("hz_data1_1", rd_data1, DW'(32'h99));
        @(negedge clock);
        check_eq("hz_data0_2", rd_data0, DW'(14));
        check_eq("hz_done", DW'(rd_done), DW'(1));
        @(negedge clock);
        check_eq("hz_busy_end", DW'(rd_busy), DW'(0));

        // Empty burst
        rd_start = 1'b1; rd_base = AW'(10); rd_pairs = AW'(0);
        @(negedge clock);
        rd_start = 1'b0;
        check_eq("empty_done", DW'(rd_done), DW'(1));
        check_eq("empty_busy", DW'(rd_busy), DW'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_eq("empty_done_off", DW'(rd_done), DW'(0));
            check_eq("empty_valid", DW'(rd_valid), DW'(0));
        end

        // Reset in the middle of a burst
        start_burst(10, 3);
        @(negedge clock);
        @(negedge clock);
        check_eq("mid_valid_pre", DW'(rd_valid), DW'(1));
        reset = 1'b1;
        #1;
        check_eq("mid_valid_rst", DW'(rd_valid), DW'(0));
        check_eq("mid_busy_rst", DW'(rd_busy), DW'(0));
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_eq("mid_no_done", DW'(rd_done), DW'(0));
            check_eq("mid_no_valid", DW'(rd_valid), DW'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
